// File: rtl/wbledpwm_fade.sv
// rtl/wbledpwm_fade.sv - Wishbone-classic LED PWM driver with per-channel polarity and hardware fade.
module wbledpwm_fade #(
  parameter int AW        = 30,
  parameter int DW        = 32,
  parameter int NLEDS     = 4,
  parameter int PWM_WIDTH = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_reset_i,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic [DW-1:0]     wb_dat_o,
  input  logic              wb_we_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  output logic              wb_ack_o,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [NLEDS-1:0]  leds
);
  localparam int SW = ((PWM_WIDTH > 8) ? PWM_WIDTH : 8) + 1;
  localparam logic [PWM_WIDTH-1:0] CNT_LAST = PWM_WIDTH'((32'd1 << PWM_WIDTH) - 32'd2);

  logic                               ack_q, ack_d;
  logic [DW-1:0]                      dat_q, dat_d;
  logic                               en_q, en_d;
  logic [15:0]                        fdiv_q, fdiv_d;
  logic [15:0]                        fcnt_q, fcnt_d;
  logic [PWM_WIDTH-1:0]               pwm_q, pwm_d;
  logic [NLEDS-1:0]                   leds_q, leds_d;
  logic [NLEDS-1:0]                   inv_q, inv_d;
  logic [NLEDS-1:0][PWM_WIDTH-1:0]    tgt_q, tgt_d;
  logic [NLEDS-1:0][PWM_WIDTH-1:0]    cur_q, cur_d;
  logic [NLEDS-1:0][7:0]              step_q, step_d;

  logic       acc, wr, wrap, tick;
  logic [5:0] adr;
  logic       unused;

  assign unused   = ^{wb_adr_i[AW-1:6], wb_sel_i, wb_dat_i};
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign leds     = leds_q;

  always_comb begin : comb_p
    logic [SW-1:0] cw, tw, sw;
    acc    = wb_cyc_i & wb_stb_i & ~ack_q;
    wr     = acc & wb_we_i;
    adr    = wb_adr_i[5:0];
    ack_d  = acc;
    dat_d  = '0;
    en_d   = en_q;
    fdiv_d = fdiv_q;
    inv_d  = inv_q;
    tgt_d  = tgt_q;
    step_d = step_q;
    cur_d  = cur_q;
    leds_d = inv_q;
    cw     = '0;
    tw     = '0;
    sw     = '0;

    wrap   = en_q && (pwm_q == CNT_LAST);
    tick   = wrap && (fcnt_q == '0);
    pwm_d  = (!en_q || wrap) ? '0 : pwm_q + PWM_WIDTH'(1);
    fcnt_d = fcnt_q;
    if (!en_q)     fcnt_d = '0;
    else if (wrap) fcnt_d = (fcnt_q == '0) ? fdiv_q : fcnt_q - 16'd1;

    // Fade logic reads target_q, so a write coincident with a tick affects only the next tick.
    for (int i = 0; i < NLEDS; i++) begin
      cw = SW'(cur_q[i]);
      tw = SW'(tgt_q[i]);
      sw = SW'(step_q[i]);
      if (en_q) begin
        leds_d[i] = (pwm_q < cur_q[i]) ^ inv_q[i];
        if (step_q[i] == 8'd0) begin
          cur_d[i] = tgt_q[i];
        end else if (tick) begin
          if (cw < tw)      cur_d[i] = (cw + sw >= tw) ? tgt_q[i] : PWM_WIDTH'(cw + sw);
          else if (cw > tw) cur_d[i] = (cw >= tw + sw) ? PWM_WIDTH'(cw - sw) : tgt_q[i];
        end
      end
    end

    if (acc && !wb_we_i) begin
      if (adr == 6'h00) begin
        dat_d[0]     = en_q;
        dat_d[31:16] = fdiv_q;
      end
      for (int i = 0; i < NLEDS; i++) begin
        if (adr == 6'h01)                          dat_d[i] = (cur_q[i] != tgt_q[i]);
        if (adr[5:4] == 2'b01 && adr[3:0] == 4'(i)) begin
          dat_d[PWM_WIDTH-1:0] = tgt_q[i];
          dat_d[23:16]         = step_q[i];
          dat_d[31]            = inv_q[i];
        end
        if (adr[5:4] == 2'b10 && adr[3:0] == 4'(i)) dat_d[PWM_WIDTH-1:0] = cur_q[i];
      end
    end

    if (wr) begin
      if (adr == 6'h00) begin
        if (wb_sel_i[0]) en_d         = wb_dat_i[0];
        if (wb_sel_i[2]) fdiv_d[7:0]  = wb_dat_i[23:16];
        if (wb_sel_i[3]) fdiv_d[15:8] = wb_dat_i[31:24];
      end
      for (int i = 0; i < NLEDS; i++) begin
        if (adr[5:4] == 2'b01 && adr[3:0] == 4'(i)) begin
          for (int b = 0; b < PWM_WIDTH; b++)
            if (wb_sel_i[b/8]) tgt_d[i][b] = wb_dat_i[b];
          if (wb_sel_i[2]) step_d[i] = wb_dat_i[23:16];
          if (wb_sel_i[3]) inv_d[i]  = wb_dat_i[31];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
    if (wb_reset_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      en_q   <= 1'b0;
      fdiv_q <= '0;
      fcnt_q <= '0;
      pwm_q  <= '0;
      leds_q <= '0;
      inv_q  <= '0;
      tgt_q  <= '0;
      cur_q  <= '0;
      step_q <= '0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      en_q   <= en_d;
      fdiv_q <= fdiv_d;
      fcnt_q <= fcnt_d;
      pwm_q  <= pwm_d;
      leds_q <= leds_d;
      inv_q  <= inv_d;
      tgt_q  <= tgt_d;
      cur_q  <= cur_d;
      step_q <= step_d;
    end
  end
endmodule

// File: tb/tb_wbledpwm_fade.sv
// tb/tb_wbledpwm_fade.sv - self-checking bench for wbledpwm_fade with a period-arithmetic reference model.
module tb_wbledpwm_fade;
  localparam int NL = 4;
  localparam int P  = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic        ack;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [NL-1:0] leds;

  int n_cmp = 0;
  int n_fail = 0;
  int cycles = 0;

  wbledpwm_fade #(.AW(30), .DW(32), .NLEDS(NL), .PWM_WIDTH(8)) dut (
    .wb_clk_i(clk), .wb_reset_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_we_i(we), .wb_sel_i(sel), .wb_ack_o(ack), .wb_cyc_i(cyc), .wb_stb_i(stb), .leds(leds)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycles <= cycles + 1;

  // Reference model: time since enable drives PWM position and tick schedule.
  logic          m_ack;
  logic [31:0]   m_dat;
  logic          m_en;
  logic [15:0]   m_div;
  int            m_t;
  logic [7:0]    m_tgt [NL];
  logic [7:0]    m_step[NL];
  logic [7:0]    m_cur [NL];
  logic          m_inv [NL];
  logic [NL-1:0] m_leds;

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r;
    r = '0;
    if (a == 0) r = {m_div, 15'd0, m_en};
    else if (a == 1) begin
      for (int i = 0; i < NL; i++) r[i] = (m_cur[i] != m_tgt[i]);
    end else if (a >= 16 && a < 16 + NL) r = {m_inv[a-16], 7'd0, m_step[a-16], 8'd0, m_tgt[a-16]};
    else if (a >= 32 && a < 32 + NL) r = {24'd0, m_cur[a-32]};
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack <= 1'b0; m_dat <= '0; m_en <= 1'b0; m_div <= '0; m_t <= 0; m_leds <= '0;
      for (int i = 0; i < NL; i++) begin
        m_tgt[i] <= '0; m_step[i] <= '0; m_cur[i] <= '0; m_inv[i] <= 1'b0;
      end
    end else begin
      bit acc, tick;
      int cnt, a, c, t, s;
      acc  = cyc && stb && !m_ack;
      a    = int'(adr[5:0]);
      cnt  = m_t % P;
      tick = m_en && (cnt == P - 1) && ((m_t / P) % (int'(m_div) + 1) == 0);
      for (int i = 0; i < NL; i++) begin
        c = m_cur[i]; t = m_tgt[i]; s = m_step[i];
        m_leds[i] <= m_en ? ((cnt < c) ^ m_inv[i]) : m_inv[i];
        if (m_en) begin
          if (s == 0) c = t;
          else if (tick && c < t) c = (c + s < t) ? c + s : t;
          else if (tick && c > t) c = (c - s > t) ? c - s : t;
        end
        m_cur[i] <= 8'(c);
      end
      m_dat <= (acc && !we) ? m_read(a) : 32'd0;
      m_ack <= acc;
      m_t   <= m_en ? m_t + 1 : 0;
      if (acc && we) begin
        if (a == 0) begin
          if (sel[0]) m_en <= dat_i[0];
          if (sel[2]) m_div[7:0] <= dat_i[23:16];
          if (sel[3]) m_div[15:8] <= dat_i[31:24];
        end else if (a >= 16 && a < 16 + NL) begin
          if (sel[0]) m_tgt[a-16]  <= dat_i[7:0];
          if (sel[2]) m_step[a-16] <= dat_i[23:16];
          if (sel[3]) m_inv[a-16]  <= dat_i[31];
        end
      end
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if (ack !== m_ack || dat_o !== m_dat || leds !== m_leds) begin
      n_fail++;
      $display("FAIL model t=%0t ack=%b/%b dat=%h/%h leds=%b/%b (dut/model)", $time, ack, m_ack, dat_o, m_dat, leds, m_leds);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic bus(input bit w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] q);
    int k;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {24'd0, a}; dat_i = d; sel = s;
    k = 0;
    do begin @(negedge clk); k++; end while (!ack && k < 8);
    chk("ack_seen", {31'd0, ack}, 32'd1);
    q = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic duty(output int hi);
    hi = 0;
    repeat (P) begin @(negedge clk); if (leds[0]) hi++; end
  endtask

  task automatic wait_cur_change(input logic [31:0] from, output logic [31:0] r);
    int it;
    it = 0;
    do begin bus(0, 6'h20, 0, 4'h0, r); it++; end while (r == from && it < 1500);
    chk("cur_change_timeout", {31'd0, (r == from)}, 32'd0);
  endtask

  initial begin
    logic [31:0] r, v;
    int hi, nv;
    logic [31:0] vals[4];
    int tms[4];

    repeat (3) @(negedge clk);
    chk("leds_in_reset", {28'd0, leds}, 32'd0);
    rst = 1'b0;

    // Reset mid-read clears ack and all registers
    bus(1, 6'h10, 32'h8010_0040, 4'hF, r);
    bus(1, 6'h00, 32'h0003_0001, 4'hF, r);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'h10;
    @(negedge clk);
    chk("ack_before_reset", {31'd0, ack}, 32'd1);
    rst = 1'b1;
    #1;
    chk("ack_in_reset", {31'd0, ack}, 32'd0);
    chk("leds_mid_reset", {28'd0, leds}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus(0, 6'h00, 0, 4'h0, r); chk("ctrl_after_reset", r, 32'd0);
    bus(0, 6'h10, 0, 4'h0, r); chk("ch0_after_reset", r, 32'd0);
    bus(0, 6'h20, 0, 4'h0, r); chk("cur0_after_reset", r, 32'd0);

    // Fixed duty 0x40 with STEP=0
    bus(1, 6'h10, 32'h0000_0040, 4'hF, r);
    bus(1, 6'h00, 32'h0000_0001, 4'hF, r);
    repeat (4) @(negedge clk);
    duty(hi); chk("duty_40", hi, 64);
    bus(0, 6'h20, 0, 4'h0, r); chk("cur0_40", r, 32'h40);
    bus(0, 6'h10, 0, 4'h0, r); chk("ch0_40", r, 32'h40);
    bus(0, 6'h11, 0, 4'h0, r); chk("ch1_zero", r, 32'd0);
    bus(1, 6'h01, 32'hFFFF_FFFF, 4'hF, r);
    bus(0, 6'h3F, 0, 4'h0, r); chk("unmapped", r, 32'd0);

    // Full-on and inverted-off both hold the pin high
    bus(1, 6'h10, 32'h0000_00FF, 4'hF, r);
    repeat (4) @(negedge clk);
    duty(hi); chk("duty_ff", hi, 255);
    bus(1, 6'h10, 32'h8000_0000, 4'hF, r);
    repeat (4) @(negedge clk);
    duty(hi); chk("duty_inv0", hi, 255);

    // Fade 0 -> 0x35 in steps of 0x10, one tick every two periods
    bus(1, 6'h00, 32'h0000_0000, 4'hF, r);
    bus(1, 6'h10, 32'h0010_0035, 4'hF, r);
    bus(1, 6'h00, 32'h0001_0001, 4'hF, r);
    bus(0, 6'h01, 0, 4'h0, r); chk("stat_busy", r, 32'h1);
    v = 0; nv = 0;
    for (int it = 0; it < 3000 && nv < 4; it++) begin
      bus(0, 6'h20, 0, 4'h0, r);
      if (r != v) begin vals[nv] = r; tms[nv] = cycles; nv++; v = r; end
    end
    chk("fade_count", nv, 4);
    if (nv == 4) begin
      chk("fade_v0", vals[0], 32'h10);
      chk("fade_v1", vals[1], 32'h20);
      chk("fade_v2", vals[2], 32'h30);
      chk("fade_v3", vals[3], 32'h35);
      for (int k = 1; k < 4; k++)
        chk("fade_interval_ok", {31'd0, (tms[k] - tms[k-1] >= 505 && tms[k] - tms[k-1] <= 515)}, 32'd1);
    end
    bus(0, 6'h01, 0, 4'h0, r); chk("stat_done", r, 32'd0);

    // Byte-lane write touches only TARGET
    bus(1, 6'h10, 32'h8077_00AA, 4'h1, r);
    @(negedge clk);
    chk("ack_single_cycle", {31'd0, ack}, 32'd0);
    bus(0, 6'h10, 0, 4'h0, r); chk("ch0_sel0", r, 32'h0010_00AA);

    // Disable mid-fade freezes CUR, re-enable resumes
    wait_cur_change(32'h35, r); chk("fade_resume_a", r, 32'h45);
    bus(1, 6'h00, 32'h0001_0000, 4'hF, r);
    repeat (1200) @(negedge clk);
    chk("leds_disabled", {28'd0, leds}, 32'd0);
    bus(0, 6'h20, 0, 4'h0, r); chk("cur_frozen", r, 32'h45);
    bus(1, 6'h00, 32'h0001_0001, 4'hF, r);
    wait_cur_change(32'h45, r); chk("fade_resume_b", r, 32'h55);
    bus(0, 6'h01, 0, 4'h0, r); chk("stat_resume", r, 32'h1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
